// File: rtl/hall_speed_sampler.sv
// Per-window signed step delta from an 8-bit wrapping hall counter, with valid/ready, overrun and stall flags.
// Optional macro HALL_SPEED_POSITION_EN adds a 16-bit signed accumulated position output.
module hall_speed_sampler #(
    parameter int unsigned PERIOD_CYCLES = 18432,
    parameter int unsigned STALL_PERIODS = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [7:0]        count_in,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic signed [7:0] sample_delta,
    output logic              overrun,
    input  logic              clear_flags,
    output logic              stalled
`ifdef HALL_SPEED_POSITION_EN
    ,
    output logic signed [15:0] position
`endif
);

    localparam logic [0:0]  ST_PRIME   = 1'b0;
    localparam logic [0:0]  ST_RUN     = 1'b1;
    localparam logic [23:0] TIMER_LAST = 24'(PERIOD_CYCLES - 1);
    localparam logic [7:0]  STALL_MAX  = 8'(STALL_PERIODS);

    // Modular difference read as two's complement; motion beyond +/-127 per window aliases.
    function automatic logic signed [7:0] wrap_delta(input logic [7:0] now, input logic [7:0] prev);
        logic [7:0] diff;
        diff = now - prev;
        return signed'(diff);
    endfunction

    function automatic logic [7:0] stall_next(input logic [7:0] cnt, input logic signed [7:0] d);
        if (d != 8'sd0)
            return 8'd0;
        else if (cnt == STALL_MAX)
            return cnt;
        else
            return cnt + 8'd1;
    endfunction

    logic [0:0]        state;
    logic [23:0]       timer;
    logic [7:0]        last_count;
    logic [7:0]        stall_cnt;
    logic              tick;
    logic              load;
    logic signed [7:0] delta_p0;
    logic [7:0]        stall_nxt;

    assign tick = enable && (timer == TIMER_LAST);
    assign load = tick && (state == ST_RUN);

    always_comb begin
        delta_p0  = wrap_delta(count_in, last_count);
        stall_nxt = stall_next(stall_cnt, delta_p0);
    end

    // Stage p0 -> output registers: sample, handshake and flags update on the load edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_PRIME;
            timer        <= 24'd0;
            last_count   <= 8'd0;
            sample_valid <= 1'b0;
            sample_delta <= 8'sd0;
            overrun      <= 1'b0;
            stalled      <= 1'b0;
            stall_cnt    <= 8'd0;
        end else begin
            if (!enable) begin
                state <= ST_PRIME;
                timer <= 24'd0;
            end else begin
                timer <= tick ? 24'd0 : timer + 24'd1;
                if (tick)
                    state <= ST_RUN;
            end

            // PRIME tracks the counter continuously so the first RUN window starts from fresh data.
            if (state == ST_PRIME || load)
                last_count <= count_in;

            if (load) begin
                sample_delta <= delta_p0;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (load && sample_valid && !sample_ready)
                overrun <= 1'b1;
            else if (clear_flags)
                overrun <= 1'b0;

            if (load) begin
                stall_cnt <= stall_nxt;
                stalled   <= (stall_nxt == STALL_MAX);
            end
        end
    end

`ifdef HALL_SPEED_POSITION_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            position <= 16'sd0;
        else if (load)
            position <= position + 16'(delta_p0);
    end
`endif

endmodule

// File: doc/hall_speed_sampler.md
Name: hall_speed_sampler

Overview:
Downstream consumer of the 8-bit wrapping hall step counter.
- Samples the counter once per fixed period and produces a signed per-period step delta (motor speed) with a valid/ready handshake.
- Raises a stall flag after a run of zero-motion periods.
- Sits between the hall counter and the motor controller / SPI register file in the robot FPGA.

Parameters:
PERIOD_CYCLES, 18432, clk cycles per sample window (1 ms at 18.432 MHz); legal range 2..2^24.
STALL_PERIODS, 50, consecutive zero-delta samples before stalled asserts; legal range 1..255.

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset
enable  in  1  sampling enable; low returns block to PRIME
count_in  in  8  wrapping hall step count from the hall counter
sample_valid  out  1  delta holding register is full
sample_ready  in  1  consumer accepts when sample_valid && sample_ready
sample_delta  out  8  signed two's-complement steps moved in last window
overrun  out  1  sticky: unread sample was overwritten
clear_flags  in  1  single-cycle pulse; clears overrun
stalled  out  1  no motion for STALL_PERIODS windows

Behaviour:
- Reset (rst_n low, async): state=PRIME, timer=0, last_count=0, sample_valid=0, sample_delta=0, overrun=0, stalled=0, stall_cnt=0.
- Period timer: 24-bit; counts 0..PERIOD_CYCLES-1 and wraps; tick=1 in the cycle timer==PERIOD_CYCLES-1. Held at 0 while enable=0.
- State PRIME:
  - last_count <= count_in every cycle; no samples emitted.
  - On the first tick with enable=1, go to RUN. That tick only captures last_count and emits no sample.
- State RUN:
  - On tick: d = count_in - last_count (mod 256, read as signed, range -128..+127); last_count <= count_in.
  - Load d into sample_delta and set sample_valid=1 on the same edge, so the sample is visible the cycle after the tick.
  - Movement of 128 or more steps per window aliases; sizing PERIOD_CYCLES to prevent this is the integrator's responsibility.
- enable=0 in any state: next state PRIME, timer=0. sample_valid/sample_delta keep their values until consumed. stall_cnt and stalled hold.
- Handshake:
  - sample_valid && sample_ready with no load: sample_valid <= 0.
  - Load while sample_valid && !sample_ready: data replaced, sample_valid stays 1, overrun <= 1.
  - Load while sample_valid && sample_ready: old sample counts as consumed; new data loaded; sample_valid stays 1; no overrun.
  - sample_delta is stable whenever sample_valid=1 and no load occurs.
- overrun:
  - Sticky; cleared by clear_flags.
  - If clear_flags and a new overrun fall in the same cycle, overrun=1 (set wins).
- Stall (RUN ticks only):
  - d==0: stall_cnt++, saturating at STALL_PERIODS. d!=0: stall_cnt=0.
  - stalled = (stall_cnt==STALL_PERIODS), registered; it updates on the same edge as the sample load.
- Wrap example: last_count=250, count_in=4 gives d=+10. last_count=3, count_in=250 gives d=-9.

Optional Feature:
Macro HALL_SPEED_POSITION_EN.
- Defined:
  - Adds output port position (16-bit signed). Reset 0.
  - On every RUN tick, position <= position + sign_extend(d); wraps modulo 2^16.
  - Unaffected by the handshake, enable, or clear_flags; holds while enable=0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use PERIOD_CYCLES=8, STALL_PERIODS=3, sample_ready=1 unless stated.
1. Reset, enable=1, count_in increments by 5 per window starting at 0 -> first tick emits nothing; each following tick gives a 1-cycle sample_valid pulse with sample_delta=0x05, one cycle after the tick.
2. Wrap and reverse: count_in 250 -> 4 across a window gives 0x0A (+10); then 4 -> 251 gives 0xF7 (-9).
3. sample_ready=0, two windows with deltas +2 then +7 -> sample_delta=0x07, sample_valid=1, overrun=1. A clear_flags pulse clears overrun; sample_ready=1 then drops sample_valid.
4. Constant count_in for 4 windows after RUN -> stalled=1 on the 3rd zero-delta sample. The next nonzero delta clears stalled on the same edge as its sample load.
5. Drive rst_n low mid-window for 1 ns with no clk edge -> all outputs 0 immediately. After release, the first tick emits no sample (PRIME).
6. enable=0 for 20 cycles while count_in moves 0 -> 100, then enable=1 -> no samples while disabled. The first tick after re-enable is a priming tick; the next tick's delta reflects only motion after that priming tick.
